// File: rtl/decoder_scan_sequencer.sv
// Address sequencer feeding a 3-to-8 line decoder: walks the lines enabled in a
// captured mask, holding each for dwell+1 cycles (or until step) with a one-cycle break-before-make gap.
module decoder_scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               step,
    input  logic               manual,
    input  logic               loop,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               A2,
    output logic               A1,
    output logic               A0,
    output logic               enable,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;

    logic [1:0]         r_state;
    logic [2:0]         r_addr;
    logic               r_enable;
    logic               r_busy;
    logic               r_done;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_dwell;
    logic [7:0]         r_mask;
    logic               r_manual;
    logic               r_loop;

    logic [2:0]         w_firstAddr;
    logic [2:0]         w_nextAddr;
    logic               w_hasHigher;
    logic               w_periodEnd;

    // Lowest set bit of the live mask; only used when a sweep is launched.
    always_comb begin
        w_firstAddr = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) w_firstAddr = 3'(i);
        end
    end

    // Next line: lowest captured bit above the current address, else wrap to the lowest bit.
    always_comb begin
        w_nextAddr  = 3'd0;
        w_hasHigher = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (r_mask[i]) w_nextAddr = 3'(i);
        end
        for (int i = 7; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_addr))) begin
                w_nextAddr  = 3'(i);
                w_hasHigher = 1'b1;
            end
        end
    end

    assign w_periodEnd = r_manual ? step : (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= 3'd0;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_dwell  <= '0;
            r_mask   <= 8'd0;
            r_manual <= 1'b0;
            r_loop   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !stop && (mask != 8'd0)) begin
                        r_state  <= S_ACTIVE;
                        r_enable <= 1'b1;
                        r_busy   <= 1'b1;
                        r_addr   <= w_firstAddr;
                        r_mask   <= mask;
                        r_dwell  <= dwell;
                        r_cnt    <= dwell;
                        r_manual <= manual;
                        r_loop   <= loop;
                    end
                end
                S_ACTIVE: begin
                    if (stop) begin
                        r_state  <= S_IDLE;
                        r_enable <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (w_periodEnd) begin
                        r_enable <= 1'b0;
                        if (w_hasHigher || r_loop) begin
                            r_state <= S_GAP;
                            r_addr  <= w_nextAddr;
                            r_cnt   <= r_dwell;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else if (!r_manual) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state  <= S_ACTIVE;
                        r_enable <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_enable <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign A2     = r_addr[2];
    assign A1     = r_addr[1];
    assign A0     = r_addr[0];
    assign enable = r_enable;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer: a table of one-shot auto sweeps
// plus hand-written sequences for loop, stop, manual step, reset and ignored starts.
module tb_decoder_scan_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       step;
    logic       manual;
    logic       loop;
    logic [7:0] mask;
    logic [7:0] dwell;
    logic       A2;
    logic       A1;
    logic       A0;
    logic       enable;
    logic       busy;
    logic       done;

    int compared;
    int mismatched;

    typedef struct {
        logic [7:0]  mask;
        logic [7:0]  dwell;
        int          expBusy;
        int          expLines;
        logic [23:0] expOrder;
        logic [2:0]  expLast;
    } vec_t;

    vec_t vecs [7];

    logic       loopEn   [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0] loopAddr [10] = '{3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7};

    decoder_scan_sequencer #(.DWELL_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .step   (step),
        .manual (manual),
        .loop   (loop),
        .mask   (mask),
        .dwell  (dwell),
        .A2     (A2),
        .A1     (A1),
        .A0     (A0),
        .enable (enable),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic st, input logic sp, input logic stp,
                                 input logic man, input logic lp,
                                 input logic [7:0] m, input logic [7:0] d);
        @(negedge clk);
        start  = st;
        stop   = sp;
        step   = stp;
        manual = man;
        loop   = lp;
        mask   = m;
        dwell  = d;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic expEn, input logic expBusy,
                               input logic expDone, input logic [2:0] expAddr);
        logic [5:0] act;
        logic [5:0] req;
        act = {enable, busy, done, A2, A1, A0};
        req = {expEn, expBusy, expDone, expAddr};
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: en/busy/done/addr got %b_%b_%b_%0d required %b_%b_%b_%0d",
                     name, act[5], act[4], act[3], act[2:0], req[5], req[4], req[3], req[2:0]);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Launch a one-shot auto sweep, scramble the live config, and record what the outputs did.
    task automatic runSweep(input logic [7:0] m, input logic [7:0] d,
                            output int busyLen, output int lineCnt,
                            output logic [23:0] order, output int runErr);
        logic       prevEn;
        logic [2:0] prevAddr;
        int         runLen;
        busyLen  = 0;
        lineCnt  = 0;
        order    = '0;
        runErr   = 0;
        runLen   = 0;
        prevEn   = 1'b0;
        prevAddr = 3'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m, d);
        nextCycle();
        while (busy && busyLen < 3000) begin
            busyLen++;
            if (enable) begin
                if (!prevEn) begin
                    if (lineCnt < 8) order[3*lineCnt +: 3] = {A2, A1, A0};
                    lineCnt++;
                    runLen = 0;
                end else if ({A2, A1, A0} != prevAddr) begin
                    runErr++;
                end
                runLen++;
            end else begin
                if (!prevEn) runErr++;
                else if (runLen != int'(d) + 1) runErr++;
            end
            if (done) runErr++;
            prevEn   = enable;
            prevAddr = {A2, A1, A0};
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ~m, ~d);
            nextCycle();
        end
        if (prevEn && runLen != int'(d) + 1) runErr++;
        start = 1'b0;
    endtask

    initial begin
        int          busyLen;
        int          lineCnt;
        logic [23:0] order;
        int          runErr;

        compared   = 0;
        mismatched = 0;
        rst_n  = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        step   = 1'b0;
        manual = 1'b0;
        loop   = 1'b0;
        mask   = 8'd0;
        dwell  = 8'd0;

        vecs[0] = '{8'hFF, 8'd0,   15,   8, 24'o76543210, 3'd7};
        vecs[1] = '{8'hA4, 8'd2,   11,   3, 24'o00000752, 3'd7};
        vecs[2] = '{8'h01, 8'd3,   4,    1, 24'o00000000, 3'd0};
        vecs[3] = '{8'h80, 8'd0,   1,    1, 24'o00000007, 3'd7};
        vecs[4] = '{8'h18, 8'd1,   5,    2, 24'o00000043, 3'd4};
        vecs[5] = '{8'h42, 8'd5,   13,   2, 24'o00000061, 3'd6};
        vecs[6] = '{8'hFF, 8'hFF,  2055, 8, 24'o76543210, 3'd7};

        #7 rst_n = 1'b0;
        #1 checkOutput("resetAsync", 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            checkOutput("resetIdle", 1'b0, 1'b0, 1'b0, 3'd0);
        end

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0);
        nextCycle();
        checkOutput("startMaskZero", 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0);
        nextCycle();
        checkOutput("startMaskZeroAfter", 1'b0, 1'b0, 1'b0, 3'd0);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'd0);
        nextCycle();
        checkOutput("startStopIdle", 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'd0);
        nextCycle();
        checkOutput("startStopIdleAfter", 1'b0, 1'b0, 1'b0, 3'd0);

        for (int v = 0; v < 7; v++) begin
            runSweep(vecs[v].mask, vecs[v].dwell, busyLen, lineCnt, order, runErr);
            checkValue($sformatf("sweep%0d.busyLen", v), busyLen, vecs[v].expBusy);
            checkValue($sformatf("sweep%0d.lines", v), lineCnt, vecs[v].expLines);
            checkValue($sformatf("sweep%0d.order", v), int'(order), int'(vecs[v].expOrder));
            checkValue($sformatf("sweep%0d.runErr", v), runErr, 0);
            checkOutput($sformatf("sweep%0d.done", v), 1'b0, 1'b0, 1'b1, vecs[v].expLast);
            nextCycle();
            checkOutput($sformatf("sweep%0d.after", v), 1'b0, 1'b0, 1'b0, vecs[v].expLast);
        end

        // Loop over lines 0 and 7; a start mid-sweep is ignored, then stop on line 7.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 8'd1);
        nextCycle();
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("loop.c%0d", c + 1), loopEn[c], 1'b1, 1'b0, loopAddr[c]);
            applyStimulus((c == 3), (c == 9), 1'b0, 1'b0, 1'b1, 8'h02, 8'd0);
            nextCycle();
        end
        checkOutput("loopStop", 1'b0, 1'b0, 1'b0, 3'd7);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0);
        nextCycle();
        checkOutput("loopStopHeld", 1'b0, 1'b0, 1'b0, 3'd7);

        // A single set bit in loop mode still inserts a gap on each wrap.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 8'd0);
        nextCycle();
        for (int c = 0; c < 6; c++) begin
            checkOutput($sformatf("wrap1.c%0d", c + 1), (c % 2 == 0), 1'b1, 1'b0, 3'd4);
            applyStimulus(1'b0, (c == 5), 1'b0, 1'b0, 1'b0, 8'h00, 8'd0);
            nextCycle();
        end
        checkOutput("wrap1Stop", 1'b0, 1'b0, 1'b0, 3'd4);

        // Manual stepping through lines 0..3.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0F, 8'd0);
        nextCycle();
        checkOutput("manual.first", 1'b1, 1'b1, 1'b0, 3'd0);
        for (int l = 0; l < 3; l++) begin
            for (int h = 0; h < 2; h++) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0F, 8'd0);
                nextCycle();
                checkOutput($sformatf("manual.hold%0d", l), 1'b1, 1'b1, 1'b0, 3'(l));
            end
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0F, 8'd0);
            nextCycle();
            checkOutput($sformatf("manual.gap%0d", l), 1'b0, 1'b1, 1'b0, 3'(l + 1));
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0F, 8'd0);
            nextCycle();
            checkOutput($sformatf("manual.line%0d", l + 1), 1'b1, 1'b1, 1'b0, 3'(l + 1));
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0F, 8'd0);
        nextCycle();
        checkOutput("manual.done", 1'b0, 1'b0, 1'b1, 3'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0F, 8'd0);
        nextCycle();
        checkOutput("manual.after", 1'b0, 1'b0, 1'b0, 3'd3);

        // step and stop together: stop wins, no done.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0F, 8'd0);
        nextCycle();
        checkOutput("stepStop.first", 1'b1, 1'b1, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0F, 8'd0);
        nextCycle();
        checkOutput("stepStop", 1'b0, 1'b0, 1'b0, 3'd0);

        // Reset mid-sweep clears immediately and the sweep does not resume.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF0, 8'd3);
        nextCycle();
        checkOutput("midReset.first", 1'b1, 1'b1, 1'b0, 3'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF0, 8'd3);
        for (int c = 0; c < 4; c++) nextCycle();
        checkOutput("midReset.before", 1'b0, 1'b1, 1'b0, 3'd5);
        #2 rst_n = 1'b0;
        #1 checkOutput("midReset.async", 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            nextCycle();
            checkOutput("midReset.idle", 1'b0, 1'b0, 1'b0, 3'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
